// File: rtl/register_file.sv
// RV32 integer register file: two combinational read ports and one synchronous write port, with x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward write data to a matching read port in the same cycle.
module register_file #(
  parameter  int XLEN      = 32,
  parameter  int REG_COUNT = 32,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [XLEN-1:0]   di3,
  input  logic              we3,
  input  logic              clk,
  output logic [XLEN-1:0]   r1,
  output logic [XLEN-1:0]   r2,
  input  logic              rst_n
);

  // Entry 0 is a constant, so the read mux can index the full address range.
  logic [XLEN-1:0] rd_array [REG_COUNT];

  assign rd_array[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < REG_COUNT; gi++) begin : g_entry
      logic [XLEN-1:0] entry_d;
      logic [XLEN-1:0] entry_q;

      always_comb begin
        entry_d = entry_q;
        if (we3 && (a3 == ADDR_W'(gi))) begin
          entry_d = di3;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign rd_array[gi] = entry_q;
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic fwd_valid;

  // Forwarding mirrors exactly the conditions under which the write would land.
  assign fwd_valid = we3 && rst_n && (a3 != '0);

  always_comb begin
    r1 = rd_array[a1];
    r2 = rd_array[a2];
    if (fwd_valid && (a1 == a3)) begin
      r1 = di3;
    end
    if (fwd_valid && (a2 == a3)) begin
      r2 = di3;
    end
  end
`else
  always_comb begin
    r1 = rd_array[a1];
    r2 = rd_array[a2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues the expected read data, and a
// monitor compares it against r1/r2 on the falling edge.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2, a3;
  logic [31:0] di3;
  logic        we3;
  logic [31:0] r1, r2;

  int checks;
  int errors;

  typedef struct {
    string       name;
    bit          port;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  register_file #(.XLEN(32), .REG_COUNT(32)) dut (
    .a1(a1), .a2(a2), .a3(a3), .di3(di3), .we3(we3),
    .clk(clk), .r1(r1), .r2(r2), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge. Checks happen at the next falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_rd(string name, bit port, logic [31:0] v);
    exp_t e;
    e.name = name;
    e.port = port;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // The monitor drains everything queued since the last rising edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e   = exp_q.pop_front();
        act = e.port ? r2 : r1;
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s r%0d actual=%h required=%h", e.name, e.port ? 2 : 1, act, e.val);
        end else begin
          $display("ok   %s r%0d = %h", e.name, e.port ? 2 : 1, act);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    we3    = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; di3 = '0;

    // 1. Reset, then sweep all addresses on both ports.
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      expect_rd($sformatf("reset_a%0d", i), 1'b0, 32'h0);
      expect_rd($sformatf("reset_a%0d", 31 - i), 1'b1, 32'h0);
      tick();
    end

    // 2. Basic write/read, plus the extreme addresses to exercise every address bit.
    a3 = 5'd1; di3 = 32'd69; we3 = 1'b1;
    tick();
    a3 = 5'd31; di3 = 32'hFFFF_FFFF;
    tick();
    a3 = 5'd16; di3 = 32'hA5A5_A5A5;
    tick();
    we3 = 1'b0;
    a1 = 5'd1; a2 = 5'd10;
    expect_rd("wr_x1", 1'b0, 32'd69);
    expect_rd("unwritten_x10", 1'b1, 32'h0);
    tick();
    a1 = 5'd31; a2 = 5'd16;
    expect_rd("wr_x31", 1'b0, 32'hFFFF_FFFF);
    expect_rd("wr_x16", 1'b1, 32'hA5A5_A5A5);
    tick();
    a1 = 5'd31; a2 = 5'd31;
    expect_rd("same_addr_p1", 1'b0, 32'hFFFF_FFFF);
    expect_rd("same_addr_p2", 1'b1, 32'hFFFF_FFFF);
    tick();

    // 3. A write to x0 is discarded and must not alias onto another entry.
    a3 = 5'd0; di3 = 32'hDEAD_BEEF; we3 = 1'b1;
    tick();
    we3 = 1'b0;
    a1 = 5'd0; a2 = 5'd1;
    expect_rd("x0_protect", 1'b0, 32'h0);
    expect_rd("x0_no_alias_x1", 1'b1, 32'd69);
    tick();

    // 4. Write enable low leaves the entry unchanged.
    a3 = 5'd5; di3 = 32'd7; we3 = 1'b0;
    tick();
    a1 = 5'd5;
    expect_rd("we_low_x5", 1'b0, 32'h0);
    tick();

    // 5. Reset beats a simultaneous write. Reads of the write address see only stored data during reset.
    rst_n = 1'b0; we3 = 1'b1; a3 = 5'd2; di3 = 32'd9;
    a1 = 5'd2;
    expect_rd("no_fwd_in_reset", 1'b0, 32'h0);
    tick();
    rst_n = 1'b1; we3 = 1'b0;
    a1 = 5'd2; a2 = 5'd1;
    expect_rd("rst_prio_x2", 1'b0, 32'h0);
    expect_rd("rst_clears_x1", 1'b1, 32'h0);
    tick();
    a1 = 5'd31; a2 = 5'd16;
    expect_rd("rst_clears_x31", 1'b0, 32'h0);
    expect_rd("rst_clears_x16", 1'b1, 32'h0);
    tick();

    // 6. Same-cycle read of the write address. Seed x3 first so the old value differs from the new one.
    a3 = 5'd3; di3 = 32'h11; we3 = 1'b1;
    tick();
    a1 = 5'd3; a2 = 5'd4; a3 = 5'd3; di3 = 32'd42; we3 = 1'b1;
`ifdef REGFILE_BYPASS_EN
    expect_rd("rw_same_before", 1'b0, 32'd42);
`else
    expect_rd("rw_same_before", 1'b0, 32'h11);
`endif
    expect_rd("rw_other_port", 1'b1, 32'h0);
    tick();
    we3 = 1'b0;
    expect_rd("rw_same_after", 1'b0, 32'd42);
    tick();
    a1 = 5'd4; a2 = 5'd3; a3 = 5'd3; di3 = 32'h55; we3 = 1'b1;
    expect_rd("rw_p2_other", 1'b0, 32'h0);
`ifdef REGFILE_BYPASS_EN
    expect_rd("rw_p2_before", 1'b1, 32'h55);
`else
    expect_rd("rw_p2_before", 1'b1, 32'd42);
`endif
    tick();
    we3 = 1'b0;
    expect_rd("rw_p2_after", 1'b1, 32'h55);
    tick();

    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
